async_fifo_read_drain: RTL

//  Read-side consumer of the async FIFO, in the read_clk domain.
//  - Pops words whenever read_empty is low and downstream space exists.
//  - Absorbs the FIFO's 1-cycle read latency and re-presents data on a valid/ready stream through a small output queue.
//  - Supports a flush command that discards FIFO contents, plus delivery/flush counters for debug.

---
 rtl/async_fifo_pkg.sv | 17 +
 rtl/drain_out_queue.sv | 89 ++++++++
 rtl/async_fifo_read_drain.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/async_fifo_pkg.sv
// ---------------------------------------------------------------------------
// async_fifo_pkg
// Shared types and default constants for the async FIFO read-side logic.
//   drain_state_t      : read-drain FSM states
//   DEFAULT_DATA_WIDTH : word width of the FIFO read port
//   DEFAULT_OUT_DEPTH  : entries in the drain output queue
//   DEFAULT_CNT_WIDTH  : width of the debug counters
// ---------------------------------------------------------------------------
package async_fifo_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} drain_state_t;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_OUT_DEPTH  = 2;
  localparam int unsigned DEFAULT_CNT_WIDTH  = 16;

endpackage

// File: rtl/drain_out_queue.sv
// ---------------------------------------------------------------------------
// drain_out_queue
// Small circular buffer that absorbs words returned by the FIFO and holds
// them until the downstream stream accepts them.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset, empties the queue
//   clear_i     : synchronous clear, empties the queue (wins over push/pop)
//   push_i      : write push_data_i at the tail
//   push_data_i : word to enqueue
//   pop_i       : remove the head word (ignored when empty)
//   count_o     : number of stored words, clog2(OUT_DEPTH)+1 bits
//   head_o      : head word, all zeros when the queue is empty
// ---------------------------------------------------------------------------
module drain_out_queue
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned OUT_DEPTH  = DEFAULT_OUT_DEPTH
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic                           push_i,
  input  logic [DATA_WIDTH-1:0]          push_data_i,
  input  logic                           pop_i,
  output logic [$clog2(OUT_DEPTH):0]     count_o,
  output logic [DATA_WIDTH-1:0]          head_o
);

  localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [OUT_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  empty;
  logic                  full;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(OUT_DEPTH));
  assign pop_ok  = pop_i && !empty;
  // A full queue may still accept a push when the head leaves on the same edge.
  assign push_ok = push_i && (!full || pop_ok);

  // Pointers are PTR_W bits wide and OUT_DEPTH is a power of two, so the
  // increment wraps modulo OUT_DEPTH on its own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count_q gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i && !clear_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/async_fifo_read_drain.sv
// ---------------------------------------------------------------------------
// async_fifo_read_drain
// Read-side consumer of the async FIFO (read_clk domain). Pops the FIFO while
// the output queue has credit, absorbs the FIFO's one-cycle read latency and
// presents the words on a valid/ready stream. A flush discards everything in
// the FIFO and reports how many words were thrown away.
//   read_clk    : clock
//   read_rst    : synchronous active-high reset
//   read_en     : FIFO pop strobe
//   read_data   : FIFO word, valid one cycle after an accepted pop
//   read_empty  : FIFO empty flag
//   enable      : level, 1 = drain FIFO into the stream
//   flush_req   : pulse, discard FIFO contents
//   flush_done  : pulse, flush finished
//   m_valid     : stream word valid
//   m_ready     : stream word accepted
//   m_data      : stream word (0 when nothing is queued)
//   pop_count   : words delivered on the stream, saturating
//   flush_count : words discarded by the last flush, saturating
// ---------------------------------------------------------------------------
module async_fifo_read_drain
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned OUT_DEPTH  = DEFAULT_OUT_DEPTH,
  parameter int unsigned CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  read_clk,
  input  logic                  read_rst,
  output logic                  read_en,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  read_empty,
  input  logic                  enable,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  pop_count,
  output logic [CNT_WIDTH-1:0]  flush_count
);

  localparam int unsigned QCW = $clog2(OUT_DEPTH) + 1;

  drain_state_t         state_q, state_d;
  logic                 inflight_q;
  logic [QCW-1:0]       q_count;
  logic [QCW-1:0]       credit_sum;
  logic                 flush_entry;
  logic                 q_push;
  logic                 xfer;
  logic [CNT_WIDTH-1:0] pop_count_q, pop_count_d;
  logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;

  // -------------------------------------------------------------------------
  // FSM next state and FIFO strobe
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    read_en     = 1'b0;
    flush_done  = 1'b0;
    flush_entry = 1'b0;
    // Queued words plus the word still returning from the FIFO must fit the
    // queue, so a pop is only issued while that sum leaves a free slot.
    credit_sum  = q_count + QCW'(inflight_q);
    unique case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d     = FLUSH;
          flush_entry = 1'b1;
        end else if (enable) begin
          state_d = RUN;
        end
      end
      RUN: begin
        read_en = !read_empty && (credit_sum < QCW'(OUT_DEPTH));
        if (flush_req) begin
          state_d     = FLUSH;
          flush_entry = 1'b1;
        end else if (!enable) begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        read_en = !read_empty;
        // Done only once the last popped word has come back and been counted.
        if (read_empty && !inflight_q) begin
          state_d    = IDLE;
          flush_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output queue
  // -------------------------------------------------------------------------
  assign q_push  = inflight_q && (state_q != FLUSH);
  assign m_valid = (q_count != '0);
  assign xfer    = m_valid && m_ready;

  drain_out_queue #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_DEPTH  (OUT_DEPTH)
  ) u_out_queue (
    .clk_i       (read_clk),
    .rst_i       (read_rst),
    .clear_i     (flush_entry),
    .push_i      (q_push),
    .push_data_i (read_data),
    .pop_i       (xfer),
    .count_o     (q_count),
    .head_o      (m_data)
  );

  // -------------------------------------------------------------------------
  // Debug counters
  // -------------------------------------------------------------------------
  always_comb begin
    pop_count_d   = pop_count_q;
    flush_count_d = flush_count_q;
    if (xfer && (pop_count_q != '1)) begin
      pop_count_d = pop_count_q + 1'b1;
    end
    if (flush_entry) begin
      // A word returning on the entry edge is dropped by the queue clear,
      // so it is the first one this flush counts.
      flush_count_d = CNT_WIDTH'(inflight_q);
    end else if ((state_q == FLUSH) && inflight_q && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + 1'b1;
    end
  end

  always_ff @(posedge read_clk) begin
    if (read_rst) begin
      state_q       <= IDLE;
      inflight_q    <= 1'b0;
      pop_count_q   <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      inflight_q    <= read_en;
      pop_count_q   <= pop_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign pop_count   = pop_count_q;
  assign flush_count = flush_count_q;

endmodule
